// File: rtl/cv32e41s_mult_arbiter.sv
// Round-robin arbiter sharing one cv32e41s_mult datapath between NUM_REQ requesters.
// Optional: define CV32E41S_MULT_ARB_BYPASS_EN to return a result in its completion cycle.
package cv32e41s_mult_arbiter_pkg;
   typedef enum logic [1:0] {
      MUL_M32 = 2'b00,
      MUL_H   = 2'b11
   } mul_opcode_e;
endpackage

module cv32e41s_mult_arbiter
   import cv32e41s_mult_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid_i,
   output logic [NUM_REQ-1:0] req_ready_o,
   input  mul_opcode_e        req_operator_i    [NUM_REQ],
   input  logic [1:0]         req_signed_mode_i [NUM_REQ],
   input  logic [31:0]        req_op_a_i        [NUM_REQ],
   input  logic [31:0]        req_op_b_i        [NUM_REQ],
   input  logic [NUM_REQ-1:0] req_kill_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [ID_W-1:0]    rsp_id_o,
   output logic [31:0]        rsp_result_o,
   output logic               mul_valid_o,
   output mul_opcode_e        mul_operator_o,
   output logic [1:0]         mul_signed_mode_o,
   output logic [31:0]        mul_op_a_o,
   output logic [31:0]        mul_op_b_o,
   input  logic [31:0]        mul_result_i,
   input  logic               mul_valid_i,
   input  logic               mul_ready_i,
   output logic               mul_ready_o,
   output logic               busy_o
);

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   mul_opcode_e         operator_q, operator_d;
   logic [1:0]          mode_q, mode_d;
   logic [DATA_W-1:0]   op_a_q, op_a_d;
   logic [DATA_W-1:0]   op_b_q, op_b_d;
   logic [DATA_W-1:0]   result_q, result_d;

   logic [NUM_REQ-1:0]  eligible;
   logic [ID_W-1:0]     grant_id;
   logic                kill_owner;

   // First eligible requester scanning upward from ptr, wrapping modulo NUM_REQ.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                 input logic [ID_W-1:0]    ptr);
      logic [ID_W-1:0] pick;
      logic            found;
      int unsigned     idx;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr) + k) % NUM_REQ;
         if (!found && elig[ID_W'(idx)]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
      return pick;
   endfunction

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      operator_d   = operator_q;
      mode_d       = mode_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      result_d     = result_q;
      req_ready_o  = '0;
      mul_valid_o  = 1'b0;
      mul_ready_o  = 1'b0;
      rsp_valid_o  = 1'b0;
      rsp_result_o = result_q;
      eligible     = req_valid_i & ~req_kill_i;
      grant_id     = rr_pick(eligible, rr_ptr_q);
      kill_owner   = req_kill_i[id_q];

      unique case (state_q)
         IDLE: begin
            // Grants are suppressed while reset is held so every output reads 0.
            if ((|eligible) && !rst) begin
               req_ready_o[grant_id] = 1'b1;
               id_d       = grant_id;
               operator_d = req_operator_i[grant_id];
               mode_d     = req_signed_mode_i[grant_id];
               op_a_d     = req_op_a_i[grant_id];
               op_b_d     = req_op_b_i[grant_id];
               rr_ptr_d   = ID_W'((32'(grant_id) + 32'd1) % NUM_REQ);
               state_d    = BUSY;
            end
         end
         BUSY: begin
            // Dropping valid on kill resets the multiplier sequence in the same cycle.
            mul_valid_o = !kill_owner;
            mul_ready_o = 1'b1;
            if (kill_owner) begin
               state_d = IDLE;
            end else if (mul_valid_i) begin
               result_d = mul_result_i;
`ifdef CV32E41S_MULT_ARB_BYPASS_EN
               if (rsp_ready_i) begin
                  rsp_valid_o  = 1'b1;
                  rsp_result_o = mul_result_i;
                  state_d      = IDLE;
               end else begin
                  state_d = RESP;
               end
`else
               state_d = RESP;
`endif
            end
         end
         RESP: begin
            rsp_valid_o = !kill_owner;
            if (kill_owner || rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         id_q       <= '0;
         operator_q <= MUL_M32;
         mode_q     <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         id_q       <= id_d;
         operator_q <= operator_d;
         mode_q     <= mode_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         result_q   <= result_d;
      end
   end

   assign rsp_id_o          = id_q;
   assign mul_operator_o    = operator_q;
   assign mul_signed_mode_o = mode_q;
   assign mul_op_a_o        = op_a_q;
   assign mul_op_b_o        = op_b_q;
   assign busy_o            = (state_q != IDLE);

   a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(req_ready_o));

   a_operands_stable: assert property (@(posedge clk) disable iff (rst)
      (state_q == BUSY && state_d == BUSY) |=>
         $stable({mul_operator_o, mul_signed_mode_o, mul_op_a_o, mul_op_b_o}));

   a_mul_ready_idle: assert property (@(posedge clk) disable iff (rst)
      !mul_valid_o |-> mul_ready_i);

endmodule

// File: tb/tb_cv32e41s_mult_arbiter.sv
// Directed plus randomized bench for cv32e41s_mult_arbiter with a behavioural multiplier.
module tb_cv32e41s_mult_arbiter;
   import cv32e41s_mult_arbiter_pkg::*;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned ID_W    = 1;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_REQ-1:0] req_valid_i;
   logic [NUM_REQ-1:0] req_ready_o;
   mul_opcode_e        req_operator_i    [NUM_REQ];
   logic [1:0]         req_signed_mode_i [NUM_REQ];
   logic [31:0]        req_op_a_i        [NUM_REQ];
   logic [31:0]        req_op_b_i        [NUM_REQ];
   logic [NUM_REQ-1:0] req_kill_i;
   logic               rsp_valid_o;
   logic               rsp_ready_i;
   logic [ID_W-1:0]    rsp_id_o;
   logic [31:0]        rsp_result_o;
   logic               mul_valid_o;
   mul_opcode_e        mul_operator_o;
   logic [1:0]         mul_signed_mode_o;
   logic [31:0]        mul_op_a_o;
   logic [31:0]        mul_op_b_o;
   logic [31:0]        mul_result_i;
   logic               mul_valid_i;
   logic               mul_ready_i;
   logic               mul_ready_o;
   logic               busy_o;

   int total = 0;
   int bad   = 0;
   int ptr_m = 0;
   logic [31:0] got;

   always #5 clk = ~clk;

   cv32e41s_mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .req_operator_i    (req_operator_i),
      .req_signed_mode_i (req_signed_mode_i),
      .req_op_a_i        (req_op_a_i),
      .req_op_b_i        (req_op_b_i),
      .req_kill_i        (req_kill_i),
      .rsp_valid_o       (rsp_valid_o),
      .rsp_ready_i       (rsp_ready_i),
      .rsp_id_o          (rsp_id_o),
      .rsp_result_o      (rsp_result_o),
      .mul_valid_o       (mul_valid_o),
      .mul_operator_o    (mul_operator_o),
      .mul_signed_mode_o (mul_signed_mode_o),
      .mul_op_a_o        (mul_op_a_o),
      .mul_op_b_o        (mul_op_b_o),
      .mul_result_i      (mul_result_i),
      .mul_valid_i       (mul_valid_i),
      .mul_ready_i       (mul_ready_i),
      .mul_ready_o       (mul_ready_o),
      .busy_o            (busy_o)
   );

   // 64-bit product with per-operand signedness; MUL_H returns the upper word.
   function automatic logic [31:0] ref_mul(input mul_opcode_e op, input logic [1:0] mode,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [65:0] ea, eb, p;
      ea = {{34{mode[0] & a[31]}}, a};
      eb = {{34{mode[1] & b[31]}}, b};
      p  = ea * eb;
      return (op == MUL_H) ? p[63:32] : p[31:0];
   endfunction

   function automatic int exp_win(input logic [NUM_REQ-1:0] v, input int p);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (v[ID_W'((p + k) % NUM_REQ)]) return (p + k) % NUM_REQ;
      end
      return 0;
   endfunction

   // Multiplier model: MUL_M32 answers in its first valid cycle, MUL_H in the fourth.
   logic [2:0] mcnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             mcnt <= '0;
      else if (!mul_valid_o || mul_valid_i) mcnt <= '0;
      else                                 mcnt <= mcnt + 3'd1;
   end
   assign mul_valid_i  = mul_valid_o && (mul_operator_o == MUL_M32 || mcnt == 3'd3);
   assign mul_ready_i  = !mul_valid_o || (mcnt == 3'd0);
   assign mul_result_i = mul_valid_i ?
      ref_mul(mul_operator_o, mul_signed_mode_o, mul_op_a_o, mul_op_b_o) : 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int id, input mul_opcode_e op, input logic [1:0] mode,
                        input logic [31:0] a, input logic [31:0] b);
      req_valid_i[ID_W'(id)]       = 1'b1;
      req_operator_i[ID_W'(id)]    = op;
      req_signed_mode_i[ID_W'(id)] = mode;
      req_op_a_i[ID_W'(id)]        = a;
      req_op_b_i[ID_W'(id)]        = b;
   endtask

   task automatic drive_rand(input int id);
      drive(id, ($urandom_range(0, 1) == 1) ? MUL_H : MUL_M32, 2'($urandom_range(0, 3)),
            $urandom(), $urandom());
   endtask

   // Expects requester id to be granted, follows the op and retires the response.
   task automatic do_op(input int id, input int hold, input bit drop, input bit b2b,
                        output logic [31:0] res);
      int w, lat, mv, nb, exp_lat;
      logic [31:0] exp_res, a, b;
      mul_opcode_e op;
      logic [1:0] mode;
      logic [NUM_REQ-1:0] exp_rdy;
      op      = req_operator_i[ID_W'(id)];
      mode    = req_signed_mode_i[ID_W'(id)];
      a       = req_op_a_i[ID_W'(id)];
      b       = req_op_b_i[ID_W'(id)];
      exp_res = ref_mul(op, mode, a, b);
      nb      = (op == MUL_H) ? 4 : 1;
      exp_lat = nb + 1;
`ifdef CV32E41S_MULT_ARB_BYPASS_EN
      if (hold == 0) exp_lat = nb;
`endif
      rsp_ready_i = (hold == 0);
      exp_rdy = NUM_REQ'(1) << id;
      w = 0;
      @(negedge clk);
      while (req_ready_o == '0 && w < 20) begin
         w++;
         @(negedge clk);
      end
      chk("grant", 32'(req_ready_o), 32'(exp_rdy));
      chk("idle_at_grant", 32'({busy_o, rsp_valid_o, mul_valid_o}), 32'd0);
      if (b2b) chk("grant_gap", 32'(w), 32'd0);
      @(posedge clk); #1;
      if (drop) req_valid_i[ID_W'(id)] = 1'b0;
      req_op_a_i[ID_W'(id)] = $urandom();
      req_op_b_i[ID_W'(id)] = $urandom();
      lat = 1;
      mv  = 0;
      @(negedge clk);
      while (!rsp_valid_o && lat < 20) begin
         if (mul_valid_o) begin
            mv++;
            chk("mul_op_a", mul_op_a_o, a);
            chk("mul_op_b", mul_op_b_o, b);
         end
         lat++;
         @(negedge clk);
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("mul_valid_cycles", 32'(mv), 32'(exp_lat - 1));
      chk("rsp_id", 32'(rsp_id_o), 32'(id));
      chk("rsp_result", rsp_result_o, exp_res);
      res = rsp_result_o;
      if (hold > 0) begin
         for (int h = 1; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid_o), 32'd1);
            chk("hold_result", rsp_result_o, exp_res);
            chk("hold_id", 32'(rsp_id_o), 32'(id));
            chk("hold_no_grant", 32'(req_ready_o), 32'd0);
         end
         @(posedge clk); #1;
         rsp_ready_i = 1'b1;
         @(negedge clk);
         chk("accept_valid", 32'(rsp_valid_o), 32'd1);
         chk("accept_result", rsp_result_o, exp_res);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst         = 1'b1;
      req_valid_i = '1;
      req_kill_i  = '0;
      rsp_ready_i = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_operator_i[i]    = MUL_M32;
         req_signed_mode_i[i] = 2'b00;
         req_op_a_i[i]        = 32'd0;
         req_op_b_i[i]        = 32'd0;
      end

      // Reset state, with requesters already valid.
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready_o), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_mul_valid", 32'(mul_valid_o), 32'd0);
      chk("rst_mul_ready", 32'(mul_ready_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id_o), 32'd0);
      chk("rst_rsp_result", rsp_result_o, 32'd0);
      chk("rst_mul_ops", mul_op_a_o | mul_op_b_o | 32'(mul_signed_mode_o) | 32'(mul_operator_o), 32'd0);
      @(posedge clk); #1;
      rst         = 1'b0;
      req_valid_i = '0;

      // Single requests, fixed values.
      drive(0, MUL_M32, 2'b00, 32'd3, 32'd5);
      do_op(0, 0, 1'b1, 1'b0, got);
      chk("m32_3x5", got, 32'd15);
      drive(1, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000);
      do_op(1, 0, 1'b1, 1'b0, got);
      chk("mulh_ss", got, 32'h4000_0000);
      drive(1, MUL_H, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op(1, 0, 1'b1, 1'b0, got);
      chk("mulh_uu", got, 32'hFFFF_FFFE);
      drive(1, MUL_H, 2'b01, 32'hFFFF_FFFF, 32'd2);
      do_op(1, 0, 1'b1, 1'b0, got);
      chk("mulh_su", got, 32'hFFFF_FFFF);

      // Both requesters held valid: grants alternate 0,1,0,1,0,1 back to back.
      drive_rand(0);
      drive_rand(1);
      for (int g = 0; g < 6; g++) begin
         drive_rand(g % 2);
         do_op(g % 2, 0, 1'b0, g > 0, got);
      end
      req_valid_i = '0;

      // Kill owner on the 2nd BUSY cycle of a MUL_H; non-owner kill ignored on the 1st.
      drive(0, MUL_H, 2'b11, $urandom(), $urandom());
      drive(1, MUL_M32, 2'b00, $urandom(), $urandom());
      @(negedge clk);
      chk("kill_grant0", 32'(req_ready_o), 32'b01);
      @(posedge clk); #1;
      req_valid_i[0] = 1'b0;
      req_kill_i     = 2'b10;
      @(negedge clk);
      chk("nonowner_kill", 32'(mul_valid_o), 32'd1);
      @(posedge clk); #1;
      req_kill_i = 2'b01;
      @(negedge clk);
      chk("kill_mul_valid", 32'(mul_valid_o), 32'd0);
      chk("kill_no_rsp", 32'(rsp_valid_o), 32'd0);
      @(posedge clk); #1;
      req_kill_i = '0;
      do_op(1, 0, 1'b1, 1'b0, got);

      // Response back-pressure for 4 cycles with another requester pending.
      drive(0, MUL_M32, 2'b00, $urandom(), $urandom());
      drive(1, MUL_H, 2'b11, $urandom(), $urandom());
      do_op(0, 4, 1'b1, 1'b0, got);
      do_op(1, 0, 1'b1, 1'b1, got);

      // Reset during the BUSY phase of a MUL_H.
      drive(0, MUL_H, 2'b00, $urandom(), $urandom());
      @(negedge clk);
      chk("rst_op_grant", 32'(req_ready_o), 32'b01);
      @(posedge clk); #1;
      req_valid_i = 2'b10;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("midrst_mul_valid", 32'(mul_valid_o), 32'd0);
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_ready", 32'(req_ready_o), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("midrst_op_a", mul_op_a_o, 32'd0);
      @(posedge clk); #1;
      rst         = 1'b0;
      req_valid_i = '0;
      drive(0, MUL_M32, 2'b00, 32'd7, 32'd6);
      do_op(0, 0, 1'b1, 1'b0, got);
      chk("post_rst_7x6", got, 32'd42);
      ptr_m = 1;

      // Random request subsets against the rotating-priority model.
      for (int n = 0; n < 30; n++) begin
         logic [NUM_REQ-1:0] v;
         int w;
         v = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         for (int i = 0; i < NUM_REQ; i++) begin
            if (v[ID_W'(i)]) drive_rand(i);
         end
         w = exp_win(v, ptr_m);
         do_op(w, int'($urandom_range(0, 2)), 1'b1, 1'b0, got);
         ptr_m = (w + 1) % NUM_REQ;
         req_valid_i = '0;
      end

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
